dma_channel_arbiter: RTL and testbench

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

---
 rtl/dma_channel_arbiter.sv | 106 ++++++++++
 tb/tb_dma_channel_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA request arbiter: picks one requesting channel (fixed or
// rotating priority, with per-channel mask) and hands it ownership of the DMAC.
module dma_channel_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  DREQ,
    input  logic        REGW,
    input  logic [15:0] Setup,
    input  logic        DACK_IN,
    input  logic        EOP_IN,
    output logic        DREQ_OUT,
    output logic [3:0]  DACK,
    output logic [1:0]  CHSEL,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_mask;
    logic        r_mode;
    logic [1:0]  r_ptr;
    logic [1:0]  r_chsel;

    logic [3:0]  w_elig;
    logic [1:0]  w_idx;
    logic [1:0]  w_win;
    logic        w_found;
    logic        w_unused;

    assign w_unused = ^Setup[15:5];

    // Priority search: fixed mode walks 0..3, rotating mode walks PTR..PTR+3 (mod 4).
    always_comb begin
        w_elig  = DREQ & ~r_mask;
        w_idx   = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_idx = r_mode ? (r_ptr + 2'(i)) : 2'(i);
            if (!w_found && w_elig[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_next   = IDLE;
        DREQ_OUT = 1'b0;
        DACK     = '0;
        BUSY     = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = w_found ? GRANT : IDLE;
            end
            GRANT: begin
                DREQ_OUT      = 1'b1;
                BUSY          = 1'b1;
                DACK[r_chsel] = DACK_IN;
                if (EOP_IN)
                    w_next = DONE;
                else if (!DREQ[r_chsel] && !DACK_IN)
                    w_next = IDLE;
                else
                    w_next = GRANT;
            end
            DONE: begin
                BUSY   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_mode  <= 1'b0;
            r_ptr   <= '0;
            r_chsel <= '0;
        end else begin
            r_state <= w_next;
            // Configuration lands on this edge; arbitration above already used the old mask.
            if (REGW) begin
                r_mask <= Setup[3:0];
                r_mode <= Setup[4];
            end
            if (r_state == IDLE && w_found)
                r_chsel <= w_win;
            if (r_state == DONE && r_mode)
                r_ptr <= r_chsel + 2'd1;
        end
    end

    assign CHSEL = r_chsel;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed, table-driven bench for dma_channel_arbiter plus a bounded
// rotating-priority grant sequence.
module tb_dma_channel_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  DREQ = '0;
    logic        REGW = 1'b0;
    logic [15:0] Setup = '0;
    logic        DACK_IN = 1'b0;
    logic        EOP_IN = 1'b0;
    logic        DREQ_OUT;
    logic [3:0]  DACK;
    logic [1:0]  CHSEL;
    logic        BUSY;

    dma_channel_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .DREQ     (DREQ),
        .REGW     (REGW),
        .Setup    (Setup),
        .DACK_IN  (DACK_IN),
        .EOP_IN   (EOP_IN),
        .DREQ_OUT (DREQ_OUT),
        .DACK     (DACK),
        .CHSEL    (CHSEL),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [3:0]  dreq;
        logic        regw;
        logic [15:0] setup;
        logic        dack_in;
        logic        eop_in;
        logic        e_dreq_out;
        logic [3:0]  e_dack;
        logic [1:0]  e_chsel;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic rst, input logic [3:0] dreq, input logic regw,
                       input logic [15:0] setup, input logic dack_in, input logic eop_in,
                       input logic e_do, input logic [3:0] e_dack, input logic [1:0] e_chsel,
                       input logic e_busy);
        vec_t v;
        v.rst = rst; v.dreq = dreq; v.regw = regw; v.setup = setup;
        v.dack_in = dack_in; v.eop_in = eop_in;
        v.e_dreq_out = e_do; v.e_dack = e_dack; v.e_chsel = e_chsel; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string name, input logic e_do, input logic [3:0] e_dack,
                             input logic [1:0] e_chsel, input logic e_busy);
        checks++;
        if (DREQ_OUT !== e_do || DACK !== e_dack || CHSEL !== e_chsel || BUSY !== e_busy) begin
            failures++;
            $display("FAIL %s: got dreq_out=%b dack=%b chsel=%0d busy=%b, expected dreq_out=%b dack=%b chsel=%0d busy=%b",
                     name, DREQ_OUT, DACK, CHSEL, BUSY, e_do, e_dack, e_chsel, e_busy);
        end
    endtask

    initial begin
        // rst dreq regw setup dack eop | dreq_out dack chsel busy
        add(1, 4'h0, 0, 16'h0000, 0, 0,  0, 4'h0, 0, 0); // reset
        add(0, 4'hA, 0, 16'h0000, 0, 0,  1, 4'h0, 1, 1); // fixed: ch1 wins over ch3
        add(0, 4'hA, 0, 16'h0000, 1, 0,  1, 4'h2, 1, 1);
        add(0, 4'hA, 0, 16'h0000, 1, 1,  0, 4'h0, 1, 1); // DONE ignores DACK_IN
        add(0, 4'h8, 0, 16'h0000, 0, 0,  0, 4'h0, 1, 0);
        add(0, 4'h8, 0, 16'h0000, 0, 0,  1, 4'h0, 3, 1);
        add(0, 4'h8, 0, 16'h0000, 0, 1,  0, 4'h0, 3, 1);
        add(0, 4'h0, 0, 16'h0000, 0, 0,  0, 4'h0, 3, 0);
        add(0, 4'h0, 0, 16'h0000, 1, 1,  0, 4'h0, 3, 0); // idle noise
        add(0, 4'h0, 0, 16'h0000, 1, 1,  0, 4'h0, 3, 0);
        add(0, 4'h0, 1, 16'h0010, 0, 0,  0, 4'h0, 3, 0); // rotating mode
        add(0, 4'hF, 0, 16'h0000, 0, 0,  1, 4'h0, 0, 1);
        add(0, 4'hF, 0, 16'h0000, 0, 1,  0, 4'h0, 0, 1);
        add(0, 4'hF, 0, 16'h0000, 0, 0,  0, 4'h0, 0, 0);
        add(0, 4'hF, 0, 16'h0000, 0, 0,  1, 4'h0, 1, 1);
        add(0, 4'hF, 0, 16'h0000, 0, 1,  0, 4'h0, 1, 1);
        add(0, 4'hF, 0, 16'h0000, 0, 0,  0, 4'h0, 1, 0);
        add(0, 4'hF, 0, 16'h0000, 0, 0,  1, 4'h0, 2, 1);
        add(0, 4'hF, 0, 16'h0000, 0, 1,  0, 4'h0, 2, 1);
        add(0, 4'hF, 0, 16'h0000, 0, 0,  0, 4'h0, 2, 0);
        add(0, 4'hF, 0, 16'h0000, 0, 0,  1, 4'h0, 3, 1);
        add(0, 4'hF, 0, 16'h0000, 0, 1,  0, 4'h0, 3, 1);
        add(0, 4'hF, 0, 16'h0000, 0, 0,  0, 4'h0, 3, 0);
        add(0, 4'hF, 0, 16'h0000, 0, 0,  1, 4'h0, 0, 1); // PTR wrapped 3 -> 0
        add(0, 4'hF, 0, 16'h0000, 0, 1,  0, 4'h0, 0, 1);
        add(0, 4'h0, 0, 16'h0000, 0, 0,  0, 4'h0, 0, 0); // PTR now 1
        add(0, 4'h4, 0, 16'h0000, 0, 0,  1, 4'h0, 2, 1);
        add(0, 4'h0, 0, 16'h0000, 0, 0,  0, 4'h0, 2, 0); // abandon
        add(0, 4'hF, 0, 16'h0000, 0, 0,  1, 4'h0, 1, 1); // PTR still 1
        add(0, 4'h0, 0, 16'h0000, 1, 0,  1, 4'h2, 1, 1); // DACK_IN keeps grant
        add(0, 4'h0, 0, 16'h0000, 0, 0,  0, 4'h0, 1, 0);
        add(0, 4'h0, 1, 16'h0005, 0, 0,  0, 4'h0, 1, 0); // fixed, mask 0101
        add(0, 4'h7, 0, 16'h0000, 0, 0,  1, 4'h0, 1, 1);
        add(0, 4'h7, 1, 16'h0007, 0, 0,  1, 4'h0, 1, 1); // mask ch1 in GRANT
        add(0, 4'h7, 0, 16'h0000, 1, 0,  1, 4'h2, 1, 1);
        add(0, 4'h7, 0, 16'h0000, 0, 1,  0, 4'h0, 1, 1);
        add(0, 4'h7, 0, 16'h0000, 0, 0,  0, 4'h0, 1, 0);
        add(0, 4'h7, 0, 16'h0000, 0, 0,  0, 4'h0, 1, 0); // all masked
        add(0, 4'h7, 1, 16'h0000, 0, 0,  0, 4'h0, 1, 0); // old mask still applies
        add(0, 4'h7, 0, 16'h0000, 0, 0,  1, 4'h0, 0, 1);
        add(0, 4'h7, 0, 16'h0000, 0, 1,  0, 4'h0, 0, 1);
        add(0, 4'h0, 0, 16'h0000, 0, 0,  0, 4'h0, 0, 0);
        add(0, 4'h0, 1, 16'h0019, 0, 0,  0, 4'h0, 0, 0); // rotating, mask 1001
        add(0, 4'hF, 0, 16'h0000, 0, 0,  1, 4'h0, 1, 1);
        add(0, 4'hF, 0, 16'h0000, 1, 0,  1, 4'h2, 1, 1);
        add(1, 4'hF, 1, 16'h0011, 1, 0,  0, 4'h0, 0, 0); // reset beats REGW
        add(0, 4'hF, 0, 16'h0000, 0, 0,  1, 4'h0, 0, 1);
        add(0, 4'hF, 0, 16'h0000, 0, 1,  0, 4'h0, 0, 1);
        add(0, 4'hF, 0, 16'h0000, 0, 0,  0, 4'h0, 0, 0);
        add(0, 4'hF, 0, 16'h0000, 0, 0,  1, 4'h0, 0, 1); // fixed mode after reset
        add(0, 4'hF, 0, 16'h0000, 0, 1,  0, 4'h0, 0, 1);
        add(1, 4'hF, 0, 16'h0000, 0, 0,  0, 4'h0, 0, 0); // reset in DONE

        #2;
        foreach (vecs[i]) begin
            RST = vecs[i].rst; DREQ = vecs[i].dreq; REGW = vecs[i].regw;
            Setup = vecs[i].setup; DACK_IN = vecs[i].dack_in; EOP_IN = vecs[i].eop_in;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].e_dreq_out, vecs[i].e_dack,
                      vecs[i].e_chsel, vecs[i].e_busy);
        end

        // Rotating grant order with DREQ held high, bounded wait per grant.
        RST = 1'b1; REGW = 1'b0; DREQ = '0; DACK_IN = 1'b0; EOP_IN = 1'b0;
        step();
        RST = 1'b0; REGW = 1'b1; Setup = 16'h0010;
        step();
        REGW = 1'b0; Setup = '0; DREQ = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int cyc;
            cyc = 0;
            while (!DREQ_OUT && cyc < 8) begin
                step();
                cyc++;
            end
            checks++;
            if (!DREQ_OUT) begin
                failures++;
                $display("FAIL rot_wait%0d: no grant within 8 cycles", k);
            end else if (CHSEL !== 2'(k % 4)) begin
                failures++;
                $display("FAIL rot_order%0d: got chsel=%0d expected %0d", k, CHSEL, k % 4);
            end
            EOP_IN = 1'b1;
            step();
            EOP_IN = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
